// File: rtl/seq_sum4_pkg.sv
// Shared types, widths and the sum-reduction helper for the serial four-operand adder.
// Build option: SEQ_SUM4_RX_SAT_EN selects a saturating (instead of wrapping) out_sum.
package seq_sum4_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned N_OPS  = 4;
    localparam int unsigned OUT_W  = 5;
    localparam int unsigned ACC_W  = DATA_W + $clog2(N_OPS);
    localparam int unsigned CNT_W  = $clog2(N_OPS);
    localparam int unsigned GRP_W  = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] sum;
        logic             ovf;
    } red_t;

    // Narrow a full group sum to OUT_W bits, flagging values that do not fit.
    function automatic red_t reduce_sum(input logic [ACC_W-1:0] full);
        red_t r;
        r.ovf = |full[ACC_W-1:OUT_W];
`ifdef SEQ_SUM4_RX_SAT_EN
        r.sum = r.ovf ? {OUT_W{1'b1}} : full[OUT_W-1:0];
`else
        r.sum = full[OUT_W-1:0];
`endif
        return r;
    endfunction

endpackage

// File: rtl/seq_sum4_rx_if.sv
// Operand-in / result-out handshake bundle for seq_sum4_rx.
interface seq_sum4_rx_if;
    import seq_sum4_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_sum;
    logic              out_ovf;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/seq_sum4_acc.sv
// Group accumulator and operand counter; sum_c/last_c describe the operand being loaded.
module seq_sum4_acc
    import seq_sum4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic [ACC_W-1:0]  sum_c,
    output logic              last_c
);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    assign sum_c  = acc + ACC_W'(data);
    assign last_c = (cnt == CNT_W'(N_OPS - 1));

    // The last operand of a group restarts accumulation from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            if (last_c) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_c;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_sum4_rx.sv
// Serial receiver summing each group of N_OPS operands and holding the result on a handshake.
// Build option: SEQ_SUM4_RX_SAT_EN (saturating out_sum, see seq_sum4_pkg).
module seq_sum4_rx
    import seq_sum4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    seq_sum4_rx_if.slave      bus,
    output logic [GRP_W-1:0]  group_cnt
);

    state_t           state;
    logic             accept;
    logic [ACC_W-1:0] sum_c;
    logic             last_c;
    red_t             red;

    // in_ready is only high in COLLECT, and clear discards any operand offered with it.
    assign accept = bus.in_valid & bus.in_ready & ~clear;
    assign red    = reduce_sum(sum_c);

    seq_sum4_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .load   (accept),
        .data   (bus.in_data),
        .sum_c  (sum_c),
        .last_c (last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
            group_cnt     <= '0;
        end else if (clear) begin
            state         <= COLLECT;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept && last_c) begin
                        state         <= PRESENT;
                        bus.in_ready  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_sum   <= red.sum;
                        bus.out_ovf   <= red.ovf;
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        state         <= COLLECT;
                        bus.in_ready  <= 1'b1;
                        bus.out_valid <= 1'b0;
                        group_cnt     <= group_cnt + GRP_W'(1);
                    end
                end
                default: begin
                    state         <= COLLECT;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_sum4_rx.md
Name: seq_sum4_rx

Overview:
Sequential receiving end of the four-operand adder path. It accepts 4-bit operands one per beat over a valid/ready handshake and accumulates each group of N_OPS operands. It then presents the group sum on a held output handshake. It sits downstream of the operand source that today drives the combinational adder, replacing four parallel buses with one serial stream.

Parameters:
DATA_W, 4, operand width in bits
N_OPS, 4, operands per group (≥2)
OUT_W, 5, width of out_sum; the full sum is wider (ACC_W = DATA_W + clog2(N_OPS) = 6)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous flush of partial group or pending result
in_valid  in  1  operand present
in_data  in  DATA_W  unsigned operand
in_ready  out  1  block can accept operand
out_valid  out  1  group result present
out_sum  out  OUT_W  group sum, reduced to OUT_W bits
out_ovf  out  1  full sum exceeded 2^OUT_W-1
out_ready  in  1  consumer accepts result
group_cnt  out  8  groups delivered, wraps 255->0

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high. On rst: state=COLLECT, acc=0, op_cnt=0, out_valid=0, out_sum=0, out_ovf=0, group_cnt=0. in_ready=1 in the first cycle after reset is released.
- Transfers: an input transfer occurs on a clock edge where in_valid & in_ready. An output transfer occurs where out_valid & out_ready.
- FSM, two states:
  - COLLECT: in_ready=1, out_valid=0. Each input transfer does acc += in_data (ACC_W bits, no loss) and op_cnt++. A transfer with op_cnt==N_OPS-1 loads the result registers from acc+in_data, resets acc and op_cnt to 0, and moves to PRESENT.
  - PRESENT: in_ready=0, out_valid=1. out_sum, out_ovf and group_cnt are stable while out_valid is high and not accepted. An output transfer returns the FSM to COLLECT and increments group_cnt (mod 256).
- Latency: out_valid rises on the cycle after the edge that accepts the last operand. The minimum group period is N_OPS+1 cycles (no overlap; in_ready is low while a result is held).
- Backpressure: out_ready=0 holds PRESENT indefinitely. Operands offered meanwhile are not accepted.
- Width rule: out_ovf = (full sum > 2^OUT_W-1). By default out_sum = full sum mod 2^OUT_W (wrap).
- clear:
  - In COLLECT it zeroes acc and op_cnt; any operand offered that cycle is dropped (clear wins).
  - In PRESENT it drops the pending result: out_valid goes to 0 next cycle, the FSM goes to COLLECT, and group_cnt does not increment.
  - clear does not reset group_cnt.
- Priority: rst > clear > handshakes.
- Reset mid-group: partial sums are discarded. No result is produced for the partial group.
- in_data is ignored whenever in_valid=0.

Optional Feature:
Macro SEQ_SUM4_RX_SAT_EN.
- Defined: on overflow, out_sum = 2^OUT_W-1 (saturate). out_ovf is still asserted.
- Undefined: out_sum wraps (mod 2^OUT_W), with out_ovf asserted.
- Handshake timing is identical in both builds.

Decomposition:
- Package seq_sum4_pkg holds: the state enum (COLLECT, PRESENT); localparams ACC_W and CNT_W = clog2(N_OPS); and a function that reduces an ACC_W sum to OUT_W bits plus an overflow flag (wrap or saturate).
- One natural sub-module: seq_sum4_acc (accumulator plus op counter with load/clear and a last-operand flag). The FSM and output registers stay in the top module.

Test Plan:
1. Operands 7,8,5,3 on consecutive cycles, out_ready=1 -> one cycle later out_valid=1, out_sum=23, out_ovf=0, then group_cnt=1.
2. Operands 3,9,1,10 with in_valid gaps, then 13,1,7,12 -> first result 23. Second result: full sum 33, out_ovf=1, out_sum=1 (wrap) or 31 (SEQ_SUM4_RX_SAT_EN).
3. Operands 9,10,11,5 with out_ready=0 for 5 cycles -> out_sum=3/31 and out_ovf=1 are held stable, and in_ready=0 throughout. Asserting out_ready then gives exactly one transfer and group_cnt increments once.
4. Two operands 15,15, then clear together with in_valid, then 1,2,3,4 -> only result is 10, out_ovf=0.
5. Result pending (PRESENT), clear asserted -> out_valid=0 next cycle, group_cnt unchanged. A following group 2,2,2,2 yields 8.
6. rst asserted after 3 operands of a group -> all outputs 0 and in_ready=1 after release. The next group 1,1,1,1 yields 4 with group_cnt=1.
